// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle RV32M multiply/divide unit for the EX stage.
//               Shift-add multiplier and restoring divider, one bit per cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;

    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_res;

    // MUL takes the unsigned path: its low half is identical either way.
    assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign w_neg_a    = w_a_signed & A[WIDTH-1];
    assign w_neg_b    = w_b_signed & B[WIDTH-1];
    assign w_mag_a    = w_neg_a ? -A : A;
    assign w_mag_b    = w_neg_b ? -B : B;

    assign w_b_zero   = (B == '0);
    assign w_ovf      = op[2] & ~op[0] & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
    assign w_special  = op[2] & (w_b_zero | w_ovf);
    assign w_special_res = w_b_zero ? (op[1] ? A : '1) : (op[1] ? '0 : A);

    // One iteration: r_lo holds multiplier / dividend, r_opnd multiplicand / divisor.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ok    = ~w_div_diff[WIDTH];

    assign w_prod    = {r_hi, r_lo};
    assign w_prod_s  = r_neg_q ? -w_prod : w_prod;
    assign w_quot    = r_neg_q ? -r_lo : r_lo;
    assign w_rem     = r_neg_r ? -r_hi : r_hi;
    assign w_fix_res = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                               : ((r_op[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0]
                                                       : w_prod_s[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op    <= op;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_hi    <= '0;
                        r_lo    <= w_mag_a;
                        r_opnd  <= w_mag_b;
                        r_cnt   <= '0;
                        if (w_special) begin
                            r_state  <= S_DONE;
                            r_result <= w_special_res;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_op[2]) begin
                        r_hi <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], w_div_ok};
                    end else begin
                        r_hi <= w_mul_sum[WIDTH:1];
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

`default_nettype wire
